multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle sequencing controller for the RV32I datapath. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB, drives the per-cycle enables and muxes for the PC, IR, register file, ALU and memory port, and handshakes with a shared single-port instruction/data memory. It sits beside the datapath and replaces purely combinational opcode decode with a state machine that also counts retired instructions.

## Interface
Parameters:
- CNT_W, 32, width of the retired-instruction counter

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  reset, synchronous, active-low
- opcode  in  7  instruction[6:0] from the IR; sampled in DECODE
- branch_cond  in  1  ALU compare result, valid in EXEC of a branch
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request; address/we stable while high
- mem_we  out  1  1 = store, 0 = read
- mem_addr_sel  out  1  0 = PC, 1 = ALU result
- ir_write_en  out  1  IR load strobe
- pc_write_en  out  1  PC load strobe
- pc_src  out  1  0 = PC+4, 1 = PC+imm target adder
- reg_write_en  out  1  register-file write strobe
- wb_sel  out  2  00 = ALU, 01 = MDR, 10 = PC+4
- alu_src_b  out  1  0 = rs2, 1 = imm
- alu_op  out  2  00 = add, 01 = compare/sub, 10 = funct decode
- illegal_instr  out  1  one-cycle pulse on unsupported opcode
- instret  out  CNT_W  retired-instruction count

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP. Outputs are decoded from the state and the latched opcode (op_q). Strobes marked "on ready" are additionally gated by mem_ready. Anything not listed is 0.
- IDLE:
  - All outputs 0.
  - Next state is FETCH.
- FETCH:
  - mem_req=1, mem_addr_sel=0, ir_write_en=mem_ready.
  - Stays in FETCH until mem_ready, then goes to DECODE.
- DECODE:
  - op_q <= opcode.
  - Supported opcodes: 0110011 R, 0010011 I, 0000011 load, 0100011 store, 1100011 branch, 1101111 jal. These go to EXEC; anything else goes to TRAP.
- EXEC:
  - R: alu_op=10, alu_src_b=0. Next state WB.
  - I: alu_op=10, alu_src_b=1. Next state WB.
  - Load/store: alu_op=00, alu_src_b=1. Next state MEM.
  - Branch: alu_op=01, alu_src_b=0, pc_write_en=1, pc_src=branch_cond; retires. Next state FETCH.
  - Jal: reg_write_en=1, wb_sel=10, pc_write_en=1, pc_src=1; retires. Next state FETCH.
- MEM:
  - mem_req=1, mem_addr_sel=1, mem_we=(op_q==store). Stays in MEM until mem_ready.
  - Load: the datapath captures read data into the MDR on mem_req & mem_ready & ~mem_we. Next state WB.
  - Store: pc_write_en=1 and pc_src=0 on ready; retires. Next state FETCH.
- WB:
  - reg_write_en=1, wb_sel=01 for load and 00 otherwise, pc_write_en=1, pc_src=0; retires. Next state FETCH.
- TRAP:
  - illegal_instr=1, pc_write_en=1, pc_src=0 (skip the instruction). No retire. Next state FETCH.
- Retire: instret increments by 1 in the retiring cycle and wraps modulo 2^CNT_W.

## Timing
- Reset: reset_n low at a rising edge sets state to IDLE and instret to 0. All outputs are 0 from that edge. reset_n overrides every other input.
- Reset mid-operation: an outstanding mem_req drops at the reset edge with no completion, and no strobes fire.
- Start-up: the first rising edge with reset_n high moves IDLE to FETCH, so mem_req rises one cycle after release.
- Handshake: a transfer completes in the cycle where mem_req & mem_ready are both high. mem_req is deasserted the next cycle unless the following state also requests. mem_ready is ignored while mem_req is low.
- Back-to-back: the cycle after a retire is FETCH with mem_req=1. There are no bubble cycles.
- Latency with zero-wait memory:
  - R/I: 4 cycles
  - Load: 5 cycles
  - Store: 4 cycles
  - Branch/jal: 3 cycles
  - Illegal: 3 cycles
- Each memory wait cycle adds 1 cycle.

## Structure
- Package riscv_ctrl_pkg contains:
  - opcode constants
  - state encoding
  - alu_op encodings
  - wb_sel encodings
  - pc_src encodings
- The next-state logic, the output decode and the op_q register stay in multicycle_ctrl.
- One sub-module, retire_counter:
  - CNT_W-bit counter with synchronous active-low clear and an inc enable.
  - Drives instret.

## Test plan
- Reset: hold reset_n low 3 cycles with mem_ready=1 → all outputs 0 and instret=0. Release → one IDLE cycle, then mem_req=1 with mem_addr_sel=0.
- R-type 0110011, mem_ready tied 1 → EXEC shows alu_op=10 and alu_src_b=0. WB shows reg_write_en=1, wb_sel=00, pc_write_en=1. instret goes 0 to 1 after 4 cycles. The next cycle is FETCH.
- Load with 2 fetch wait cycles and 3 data wait cycles:
  - mem_req is held throughout each wait.
  - ir_write_en is high only in the ready cycle.
  - WB occurs in cycle 10 with wb_sel=01.
- Branch with branch_cond=1, then again with branch_cond=0 → each EXEC shows pc_write_en=1 with pc_src=1 and then 0. reg_write_en is never asserted. Each takes 3 cycles.
- Store → MEM shows mem_we=1 and mem_addr_sel=1, and the PC is written only on mem_ready. reg_write_en is never asserted.
- Illegal opcode and reset during MEM:
  - Opcode 0000000 → illegal_instr pulses for one cycle and pc_src=0, with instret unchanged.
  - Assert reset_n low during a MEM wait → mem_req=0 from the reset edge.
  - With CNT_W=4, 16 retires wrap instret to 0.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle sequencing controller:
// opcodes, FSM states, datapath mux selects and the control-word bundle.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_e;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_CMP   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MDR = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic PC_SRC_PLUS4  = 1'b0;
  localparam logic PC_SRC_TARGET = 1'b1;

  // Per-cycle control word driven to the datapath and memory port.
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       ir_write_en;
    logic       pc_write_en;
    logic       pc_src;
    logic       reg_write_en;
    logic [1:0] wb_sel;
    logic       alu_src_b;
    logic [1:0] alu_op;
    logic       illegal_instr;
  } ctrl_t;

  function automatic logic is_supported(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL: return 1'b1;
      default:                                          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/retire_counter.sv
// Retired-instruction counter: synchronous active-low clear, +1 on inc,
// wraps modulo 2^CNT_W.
module retire_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc) count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!clr_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I datapath with
// a shared single-port memory handshake and a retired-instruction counter.
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [6:0]       opcode,
  input  logic             branch_cond,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_write_en,
  output logic             pc_write_en,
  output logic             pc_src,
  output logic             reg_write_en,
  output logic [1:0]       wb_sel,
  output logic             alu_src_b,
  output logic [1:0]       alu_op,
  output logic             illegal_instr,
  output logic [CNT_W-1:0] instret
);

  state_e     state_q;
  state_e     state_d;
  logic [6:0] op_q;
  logic [6:0] op_d;
  ctrl_t      ctrl_c;
  logic       retire_c;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Next-state and opcode latch.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      ST_IDLE:  state_d = ST_FETCH;
      ST_FETCH: if (mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        op_d    = opcode;
        state_d = is_supported(opcode) ? ST_EXEC : ST_TRAP;
      end
      ST_EXEC: begin
        case (op_q)
          OP_R, OP_I:        state_d = ST_WB;
          OP_LOAD, OP_STORE: state_d = ST_MEM;
          default:           state_d = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        if (mem_ready) state_d = (op_q == OP_STORE) ? ST_FETCH : ST_WB;
      end
      ST_WB:   state_d = ST_FETCH;
      ST_TRAP: state_d = ST_FETCH;
      default: state_d = ST_IDLE;
    endcase
  end

  // Control word decoded from state and latched opcode; ready-gated strobes use mem_ready.
  always_comb begin
    ctrl_c   = '0;
    retire_c = 1'b0;
    case (state_q)
      ST_FETCH: begin
        ctrl_c.mem_req      = 1'b1;
        ctrl_c.mem_addr_sel = 1'b0;
        ctrl_c.ir_write_en  = mem_ready;
      end
      ST_EXEC: begin
        case (op_q)
          OP_R: begin
            ctrl_c.alu_op    = ALU_FUNCT;
            ctrl_c.alu_src_b = 1'b0;
          end
          OP_I: begin
            ctrl_c.alu_op    = ALU_FUNCT;
            ctrl_c.alu_src_b = 1'b1;
          end
          OP_LOAD, OP_STORE: begin
            ctrl_c.alu_op    = ALU_ADD;
            ctrl_c.alu_src_b = 1'b1;
          end
          OP_BRANCH: begin
            ctrl_c.alu_op      = ALU_CMP;
            ctrl_c.alu_src_b   = 1'b0;
            ctrl_c.pc_write_en = 1'b1;
            ctrl_c.pc_src      = branch_cond;
            retire_c           = 1'b1;
          end
          OP_JAL: begin
            ctrl_c.reg_write_en = 1'b1;
            ctrl_c.wb_sel       = WB_PC4;
            ctrl_c.pc_write_en  = 1'b1;
            ctrl_c.pc_src       = PC_SRC_TARGET;
            retire_c            = 1'b1;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        ctrl_c.mem_req      = 1'b1;
        ctrl_c.mem_addr_sel = 1'b1;
        ctrl_c.mem_we       = (op_q == OP_STORE);
        if ((op_q == OP_STORE) && mem_ready) begin
          ctrl_c.pc_write_en = 1'b1;
          ctrl_c.pc_src      = PC_SRC_PLUS4;
          retire_c           = 1'b1;
        end
      end
      ST_WB: begin
        ctrl_c.reg_write_en = 1'b1;
        ctrl_c.wb_sel       = (op_q == OP_LOAD) ? WB_MDR : WB_ALU;
        ctrl_c.pc_write_en  = 1'b1;
        ctrl_c.pc_src       = PC_SRC_PLUS4;
        retire_c            = 1'b1;
      end
      ST_TRAP: begin
        ctrl_c.illegal_instr = 1'b1;
        ctrl_c.pc_write_en   = 1'b1;
        ctrl_c.pc_src        = PC_SRC_PLUS4;
      end
      default: ;
    endcase
  end

  assign mem_req       = ctrl_c.mem_req;
  assign mem_we        = ctrl_c.mem_we;
  assign mem_addr_sel  = ctrl_c.mem_addr_sel;
  assign ir_write_en   = ctrl_c.ir_write_en;
  assign pc_write_en   = ctrl_c.pc_write_en;
  assign pc_src        = ctrl_c.pc_src;
  assign reg_write_en  = ctrl_c.reg_write_en;
  assign wb_sel        = ctrl_c.wb_sel;
  assign alu_src_b     = ctrl_c.alu_src_b;
  assign alu_op        = ctrl_c.alu_op;
  assign illegal_instr = ctrl_c.illegal_instr;

  retire_counter #(
    .CNT_W (CNT_W)
  ) u_retire_counter (
    .clk   (clk),
    .clr_n (reset_n),
    .inc   (retire_c),
    .count (instret)
  );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: each instruction is expanded into an expected
// per-cycle trace from the opcode behaviour table, then replayed with random fill.
module tb_multicycle_ctrl;

  localparam int unsigned CNT_W = 4;

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_LD  = 7'b0000011;
  localparam logic [6:0] OPC_ST  = 7'b0100011;
  localparam logic [6:0] OPC_BR  = 7'b1100011;
  localparam logic [6:0] OPC_JAL = 7'b1101111;

  localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_JAL = 5, K_ILL = 6;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       ir_write_en;
    logic       pc_write_en;
    logic       pc_src;
    logic       reg_write_en;
    logic [1:0] wb_sel;
    logic       alu_src_b;
    logic [1:0] alu_op;
    logic       illegal_instr;
  } outs_t;

  typedef struct {
    outs_t      exp;
    logic       rdy;
    bit         rdy_rand;
    logic [6:0] opc;
    bit         opc_rand;
    logic       bc;
    bit         bc_rand;
    bit         retire;
  } step_t;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [6:0]       opcode;
  logic             branch_cond;
  logic             mem_ready;
  logic             mem_req, mem_we, mem_addr_sel, ir_write_en, pc_write_en, pc_src;
  logic             reg_write_en, alu_src_b, illegal_instr;
  logic [1:0]       wb_sel, alu_op;
  logic [CNT_W-1:0] instret;

  int               vectors = 0;
  int               miscompares = 0;
  logic [CNT_W-1:0] model_cnt = '0;
  step_t            sched[$];

  multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .opcode        (opcode),
    .branch_cond   (branch_cond),
    .mem_ready     (mem_ready),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr_sel  (mem_addr_sel),
    .ir_write_en   (ir_write_en),
    .pc_write_en   (pc_write_en),
    .pc_src        (pc_src),
    .reg_write_en  (reg_write_en),
    .wb_sel        (wb_sel),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .illegal_instr (illegal_instr),
    .instret       (instret)
  );

  always #5 clk = ~clk;

  function automatic bit is_sup(input logic [6:0] o);
    return (o == OPC_R) || (o == OPC_I) || (o == OPC_LD) || (o == OPC_ST) ||
           (o == OPC_BR) || (o == OPC_JAL);
  endfunction

  function automatic logic [6:0] rand_illegal();
    logic [6:0] o;
    do o = 7'($urandom); while (is_sup(o));
    return o;
  endfunction

  function automatic logic [6:0] opc_of(input int k);
    case (k)
      K_R:     return OPC_R;
      K_I:     return OPC_I;
      K_LD:    return OPC_LD;
      K_ST:    return OPC_ST;
      K_BR:    return OPC_BR;
      K_JAL:   return OPC_JAL;
      default: return rand_illegal();
    endcase
  endfunction

  function automatic void add(input outs_t e, input logic rdy, input bit rdy_rand,
                              input logic [6:0] opc, input bit opc_rand,
                              input logic bc, input bit bc_rand, input bit ret);
    step_t t;
    t.exp = e; t.rdy = rdy; t.rdy_rand = rdy_rand; t.opc = opc; t.opc_rand = opc_rand;
    t.bc = bc; t.bc_rand = bc_rand; t.retire = ret;
    sched.push_back(t);
  endfunction

  // Expected cycle-by-cycle trace of one instruction; fw/mw are memory wait cycles.
  function automatic void gen_instr(input int k, input logic [6:0] opc, input logic bc,
                                    input int fw, input int mw);
    outs_t e;
    for (int i = 0; i < fw; i++) begin
      e = '0; e.mem_req = 1'b1;
      add(e, 1'b0, 1'b0, 7'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    end
    e = '0; e.mem_req = 1'b1; e.ir_write_en = 1'b1;
    add(e, 1'b1, 1'b0, 7'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    e = '0;
    add(e, 1'b0, 1'b1, opc, 1'b0, 1'b0, 1'b1, 1'b0);
    e = '0;
    case (k)
      K_R, K_I: begin
        e.alu_op = 2'b10; e.alu_src_b = (k == K_I);
        add(e, 1'b0, 1'b1, 7'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        e = '0; e.reg_write_en = 1'b1; e.wb_sel = 2'b00; e.pc_write_en = 1'b1;
        add(e, 1'b0, 1'b1, 7'd0, 1'b1, 1'b0, 1'b1, 1'b1);
      end
      K_LD, K_ST: begin
        e.alu_op = 2'b00; e.alu_src_b = 1'b1;
        add(e, 1'b0, 1'b1, 7'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        e = '0; e.mem_req = 1'b1; e.mem_addr_sel = 1'b1; e.mem_we = (k == K_ST);
        for (int i = 0; i < mw; i++) add(e, 1'b0, 1'b0, 7'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        if (k == K_ST) e.pc_write_en = 1'b1;
        add(e, 1'b1, 1'b0, 7'd0, 1'b1, 1'b0, 1'b1, k == K_ST);
        if (k == K_LD) begin
          e = '0; e.reg_write_en = 1'b1; e.wb_sel = 2'b01; e.pc_write_en = 1'b1;
          add(e, 1'b0, 1'b1, 7'd0, 1'b1, 1'b0, 1'b1, 1'b1);
        end
      end
      K_BR: begin
        e.alu_op = 2'b01; e.pc_write_en = 1'b1; e.pc_src = bc;
        add(e, 1'b0, 1'b1, 7'd0, 1'b1, bc, 1'b0, 1'b1);
      end
      K_JAL: begin
        e.reg_write_en = 1'b1; e.wb_sel = 2'b10; e.pc_write_en = 1'b1; e.pc_src = 1'b1;
        add(e, 1'b0, 1'b1, 7'd0, 1'b1, 1'b0, 1'b1, 1'b1);
      end
      default: begin
        e.illegal_instr = 1'b1; e.pc_write_en = 1'b1;
        add(e, 1'b0, 1'b1, 7'd0, 1'b1, 1'b0, 1'b1, 1'b0);
      end
    endcase
  endfunction

  // Drive one cycle just after the rising edge, sample on the falling edge.
  task automatic step(input step_t s, output outs_t act, output logic [CNT_W-1:0] cnt);
    mem_ready   = s.rdy_rand ? 1'($urandom) : s.rdy;
    opcode      = s.opc_rand ? 7'($urandom) : s.opc;
    branch_cond = s.bc_rand  ? 1'($urandom) : s.bc;
    @(negedge clk);
    act = {mem_req, mem_we, mem_addr_sel, ir_write_en, pc_write_en, pc_src,
           reg_write_en, wb_sel, alu_src_b, alu_op, illegal_instr};
    cnt = instret;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step_t s; outs_t act; logic [CNT_W-1:0] cnt;
    reset_n = 1'b0; mem_ready = 1'b1; opcode = '0; branch_cond = 1'b0;
    @(posedge clk); #1;
    sched.delete();
    for (int i = 0; i < 3; i++) add('0, 1'b1, 1'b0, 7'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    add('0, 1'b0, 1'b1, 7'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) reset_n = 1'b1;
      step(sched[i], act, cnt);
      vectors++;
      if (act !== sched[i].exp) begin
        miscompares++;
        $display("FAIL reset cycle %0d: outputs got %h want %h", i, act, sched[i].exp);
      end
      vectors++;
      if (cnt !== model_cnt) begin
        miscompares++;
        $display("FAIL reset instret cycle %0d: got %0d want %0d", i, cnt, model_cnt);
      end
    end
    sched.delete();
  endtask

  task automatic run_trace(input string name);
    step_t s; outs_t act; logic [CNT_W-1:0] cnt; int idx;
    idx = 0;
    while (sched.size() > 0) begin
      s = sched.pop_front();
      step(s, act, cnt);
      vectors++;
      if (act !== s.exp) begin
        miscompares++;
        $display("FAIL %s cycle %0d: outputs got %h want %h", name, idx, act, s.exp);
      end
      vectors++;
      if (cnt !== model_cnt) begin
        miscompares++;
        $display("FAIL %s instret cycle %0d: got %0d want %0d", name, idx, cnt, model_cnt);
      end
      if (s.retire) model_cnt = model_cnt + 1'b1;
      idx++;
    end
  endtask

  task automatic test_r_type();
    gen_instr(K_R, OPC_R, 1'b0, 0, 0);
    gen_instr(K_I, OPC_I, 1'b0, 0, 0);
    run_trace("r_i_type");
  endtask

  task automatic test_load_waits();
    gen_instr(K_LD, OPC_LD, 1'b0, 2, 3);
    run_trace("load_waits");
  endtask

  task automatic test_branch();
    gen_instr(K_BR, OPC_BR, 1'b1, 0, 0);
    gen_instr(K_BR, OPC_BR, 1'b0, 0, 0);
    gen_instr(K_JAL, OPC_JAL, 1'b0, 1, 0);
    run_trace("branch_jal");
  endtask

  task automatic test_store();
    gen_instr(K_ST, OPC_ST, 1'b0, 0, 0);
    gen_instr(K_ST, OPC_ST, 1'b0, 1, 2);
    run_trace("store");
  endtask

  task automatic test_illegal();
    gen_instr(K_ILL, 7'b0000000, 1'b0, 0, 0);
    for (int i = 0; i < 3; i++) gen_instr(K_ILL, rand_illegal(), 1'b0, 0, 1);
    run_trace("illegal");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      int k;
      k = int'($urandom_range(0, 6));
      gen_instr(k, opc_of(k), 1'($urandom), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)));
    end
    run_trace("back_to_back");
  endtask

  task automatic test_reset_mid_mem();
    step_t s; outs_t act; logic [CNT_W-1:0] cnt;
    gen_instr(K_LD, OPC_LD, 1'b0, 1, 3);
    sched = sched[0:5];
    for (int i = 0; i < 6; i++) begin
      s = sched[i];
      if (i == 5) reset_n = 1'b0;
      step(s, act, cnt);
      vectors++;
      if (act !== s.exp) begin
        miscompares++;
        $display("FAIL reset_mid_mem cycle %0d: outputs got %h want %h", i, act, s.exp);
      end
    end
    sched.delete();
    model_cnt = '0;
    add('0, 1'b1, 1'b0, 7'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    add('0, 1'b1, 1'b0, 7'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    add('0, 1'b1, 1'b0, 7'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      s = sched[i];
      if (i == 2) reset_n = 1'b1;
      step(s, act, cnt);
      vectors++;
      if (act !== s.exp) begin
        miscompares++;
        $display("FAIL reset_mid_mem hold %0d: outputs got %h want %h", i, act, s.exp);
      end
      vectors++;
      if (cnt !== model_cnt) begin
        miscompares++;
        $display("FAIL reset_mid_mem instret %0d: got %0d want %0d", i, cnt, model_cnt);
      end
    end
    sched.delete();
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 16; i++) gen_instr(K_JAL, OPC_JAL, 1'b0, int'($urandom_range(0, 1)), 0);
    run_trace("wrap");
    vectors++;
    if (instret !== 4'd0) begin
      miscompares++;
      $display("FAIL wrap final instret: got %0d want 0", instret);
    end
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_load_waits();
    test_branch();
    test_store();
    test_illegal();
    test_back_to_back();
    test_reset_mid_mem();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
